// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and constants.
// Defines the RAM write payload, the RAM select bit inside dest_ram_id,
// and the default south starvation bound.
package vector_cache_pkg;

  localparam int unsigned RAM_ID_W         = 2;
  localparam int unsigned ADDR_W           = 8;
  localparam int unsigned BE_W             = 4;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned RAM_SEL_BIT      = 0;
  localparam int unsigned SOUTH_STARVE_MAX = 4;

  typedef struct packed {
    logic [RAM_ID_W-1:0] dest_ram_id;
    logic [ADDR_W-1:0]   addr;
  } req_cmd_pld_t;

  typedef struct packed {
    req_cmd_pld_t    req_cmd_pld;
    logic [BE_W-1:0] be;
  } write_cmd_t;

  typedef struct packed {
    write_cmd_t        write_cmd;
    logic [DATA_W-1:0] data;
  } write_ram_pld_t;

endpackage

// File: rtl/south_write_arb_lane.sv
// One south lane: arbitrates LFDB refill vs south write onto the lane's
// even/odd RAM slot pair, tracks south starvation, and owns both slots.
// Ports: lfdb/south vld/pld in, rdy out (combinational grants);
//        ram_vld/ram_pld registered slots, ram_rdy in; conflict_c pulse out.
module south_write_arb_lane
  import vector_cache_pkg::*;
#(
  parameter int unsigned STARVE_MAX = SOUTH_STARVE_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           lfdb_vld,
  input  write_ram_pld_t lfdb_pld,
  output logic           lfdb_rdy,
  input  logic           south_vld,
  input  write_ram_pld_t south_pld,
  output logic           south_rdy,
  output logic [1:0]     ram_vld,
  output write_ram_pld_t ram_pld [2],
  input  logic [1:0]     ram_rdy,
  output logic           conflict_c
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]  starve_q, starve_d;
  logic [1:0]     ram_vld_q, ram_vld_d;
  write_ram_pld_t ram_pld_q [2];
  write_ram_pld_t ram_pld_d [2];

  logic       t_l, t_s, same_c, lfdb_gnt, south_gnt;
  logic [1:0] free_c;

  // Grant selection, starvation tracking and slot next-state.
  always_comb begin
    t_l        = lfdb_pld.write_cmd.req_cmd_pld.dest_ram_id[RAM_SEL_BIT];
    t_s        = south_pld.write_cmd.req_cmd_pld.dest_ram_id[RAM_SEL_BIT];
    free_c     = ~ram_vld_q | ram_rdy;
    same_c     = lfdb_vld & south_vld & (t_l == t_s);
    lfdb_gnt   = 1'b0;
    south_gnt  = 1'b0;
    conflict_c = 1'b0;
    starve_d   = starve_q;
    ram_vld_d  = ram_vld_q;
    ram_pld_d  = ram_pld_q;

    if (same_c) begin
      // A busy slot stalls both sides without counting as a conflict.
      if (free_c[t_l]) begin
        conflict_c = 1'b1;
        if (starve_q == SW'(STARVE_MAX)) south_gnt = 1'b1;
        else                             lfdb_gnt  = 1'b1;
      end
    end else begin
      lfdb_gnt  = lfdb_vld  & free_c[t_l];
      south_gnt = south_vld & free_c[t_s];
    end

    if (south_gnt) begin
      starve_d = '0;
    end else if (conflict_c && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end

    for (int k = 0; k < 2; k++) begin
      if (lfdb_gnt && (t_l == 1'(k))) begin
        ram_vld_d[k] = 1'b1;
        ram_pld_d[k] = lfdb_pld;
      end else if (south_gnt && (t_s == 1'(k))) begin
        ram_vld_d[k] = 1'b1;
        ram_pld_d[k] = south_pld;
      end else if (ram_rdy[k]) begin
        ram_vld_d[k] = 1'b0;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      ram_vld_q <= '0;
      ram_pld_q <= '{default: '0};
    end else begin
      starve_q  <= starve_d;
      ram_vld_q <= ram_vld_d;
      ram_pld_q <= ram_pld_d;
    end
  end

  assign lfdb_rdy  = lfdb_gnt;
  assign south_rdy = south_gnt;
  assign ram_vld   = ram_vld_q;
  assign ram_pld   = ram_pld_q;

endmodule

// File: rtl/south_write_arb.sv
// South write channel arbiter: one lane arbiter per south lane driving
// RAM slots 2i/2i+1, plus a saturating conflict counter for perf monitoring.
// Ports: lfdb_*/south_* request channels per lane, ram_* write ports per RAM,
//        conflict_cnt 16-bit saturating conflict count.
module south_write_arb
  import vector_cache_pkg::*;
#(
  parameter int unsigned LANE_NUM   = 4,
  parameter int unsigned STARVE_MAX = SOUTH_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANE_NUM-1:0]   lfdb_vld,
  input  write_ram_pld_t        lfdb_pld [LANE_NUM],
  output logic [LANE_NUM-1:0]   lfdb_rdy,
  input  logic [LANE_NUM-1:0]   south_vld,
  input  write_ram_pld_t        south_pld [LANE_NUM],
  output logic [LANE_NUM-1:0]   south_rdy,
  output logic [2*LANE_NUM-1:0] ram_vld,
  output write_ram_pld_t        ram_pld [2*LANE_NUM],
  input  logic [2*LANE_NUM-1:0] ram_rdy,
  output logic [15:0]           conflict_cnt
);

  localparam int unsigned CW   = 16;
  localparam int unsigned SUMW = $clog2(LANE_NUM + 1);

  logic [LANE_NUM-1:0] conflict_c;
  write_ram_pld_t      lane_pld [LANE_NUM][2];
  logic [SUMW-1:0]     conf_sum_c;
  logic [CW:0]         cnt_sum_c;
  logic [CW-1:0]       cnt_q, cnt_d;

  for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
    south_write_arb_lane #(.STARVE_MAX(STARVE_MAX)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .lfdb_vld   (lfdb_vld[i]),
      .lfdb_pld   (lfdb_pld[i]),
      .lfdb_rdy   (lfdb_rdy[i]),
      .south_vld  (south_vld[i]),
      .south_pld  (south_pld[i]),
      .south_rdy  (south_rdy[i]),
      .ram_vld    (ram_vld[2*i +: 2]),
      .ram_pld    (lane_pld[i]),
      .ram_rdy    (ram_rdy[2*i +: 2]),
      .conflict_c (conflict_c[i])
    );
    assign ram_pld[2*i]   = lane_pld[i][0];
    assign ram_pld[2*i+1] = lane_pld[i][1];
  end

  // Sum per-lane conflict pulses; the extra sum bit flags saturation.
  always_comb begin
    conf_sum_c = '0;
    for (int i = 0; i < LANE_NUM; i++) begin
      conf_sum_c = conf_sum_c + SUMW'(conflict_c[i]);
    end
    cnt_sum_c = {1'b0, cnt_q} + (CW+1)'(conf_sum_c);
    cnt_d     = cnt_sum_c[CW] ? {CW{1'b1}} : cnt_sum_c[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_south_write_arb.sv
// Directed bench for south_write_arb with a payload scoreboard.
module tb_south_write_arb;
  import vector_cache_pkg::*;

  localparam int unsigned LANE_NUM = 4;
  localparam int unsigned NRAM     = 2 * LANE_NUM;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [LANE_NUM-1:0] lfdb_vld, lfdb_rdy, south_vld, south_rdy;
  write_ram_pld_t      lfdb_pld  [LANE_NUM];
  write_ram_pld_t      south_pld [LANE_NUM];
  logic [NRAM-1:0]     ram_vld, ram_rdy;
  write_ram_pld_t      ram_pld [NRAM];
  logic [15:0]         conflict_cnt;

  always #5 clk = ~clk;

  south_write_arb #(.LANE_NUM(LANE_NUM), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lfdb_vld     (lfdb_vld),
    .lfdb_pld     (lfdb_pld),
    .lfdb_rdy     (lfdb_rdy),
    .south_vld    (south_vld),
    .south_pld    (south_pld),
    .south_rdy    (south_rdy),
    .ram_vld      (ram_vld),
    .ram_pld      (ram_pld),
    .ram_rdy      (ram_rdy),
    .conflict_cnt (conflict_cnt)
  );

  typedef struct {
    int unsigned    ram;
    write_ram_pld_t pld;
  } sb_t;

  sb_t             sb_q [$];
  logic [NRAM-1:0] exp_vld;
  int unsigned     exp_cc;
  int unsigned     n_checks = 0;
  int unsigned     n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic write_ram_pld_t mk(input logic d, input logic [31:0] data);
    write_ram_pld_t p;
    p = '0;
    p.write_cmd.req_cmd_pld.dest_ram_id[RAM_SEL_BIT] = d;
    p.write_cmd.req_cmd_pld.addr = data[7:0];
    p.write_cmd.be = 4'hF;
    p.data = data;
    return p;
  endfunction

  function automatic logic dbit(input write_ram_pld_t p);
    return p.write_cmd.req_cmd_pld.dest_ram_id[RAM_SEL_BIT];
  endfunction

  // One cycle: check grants, push expected slot loads, clock, then drain the scoreboard.
  task automatic step(input string tag, input logic [LANE_NUM-1:0] el,
                      input logic [LANE_NUM-1:0] es, input int unsigned nconf);
    sb_t e;
    #1;
    chk($sformatf("%s lfdb_rdy", tag), 64'(lfdb_rdy), 64'(el));
    chk($sformatf("%s south_rdy", tag), 64'(south_rdy), 64'(es));
    exp_vld = exp_vld & ~ram_rdy;
    for (int i = 0; i < LANE_NUM; i++) begin
      if (el[i]) begin
        e.ram = 2*i + int'(dbit(lfdb_pld[i]));
        e.pld = lfdb_pld[i];
        sb_q.push_back(e);
        exp_vld[e.ram] = 1'b1;
      end
      if (es[i]) begin
        e.ram = 2*i + int'(dbit(south_pld[i]));
        e.pld = south_pld[i];
        sb_q.push_back(e);
        exp_vld[e.ram] = 1'b1;
      end
    end
    exp_cc = (exp_cc + nconf > 32'hFFFF) ? 32'hFFFF : exp_cc + nconf;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("%s ram_pld[%0d]", tag, e.ram), 64'(ram_pld[e.ram]), 64'(e.pld));
    end
    chk($sformatf("%s ram_vld", tag), 64'(ram_vld), 64'(exp_vld));
    chk($sformatf("%s conflict_cnt", tag), 64'(conflict_cnt), 64'(exp_cc));
  endtask

  initial begin
    logic [31:0]    ld, sd;
    logic           sw;
    write_ram_pld_t held;

    rst_n     = 1'b0;
    lfdb_vld  = '0;
    south_vld = '0;
    ram_rdy   = '0;
    for (int i = 0; i < LANE_NUM; i++) begin
      lfdb_pld[i]  = '0;
      south_pld[i] = '0;
    end
    exp_vld = '0;
    exp_cc  = 0;

    // Reset state
    #1;
    chk("reset ram_vld", 64'(ram_vld), 64'h0);
    chk("reset conflict_cnt", 64'(conflict_cnt), 64'h0);
    chk("reset lfdb_rdy", 64'(lfdb_rdy), 64'h0);
    chk("reset south_rdy", 64'(south_rdy), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Lane 0 LFDB to even RAM, then drain
    lfdb_vld[0] = 1'b1;
    lfdb_pld[0] = mk(1'b0, 32'hA000_0001);
    step("l0 load", 4'b0001, 4'b0000, 0);
    lfdb_vld = '0;
    ram_rdy  = '1;
    step("l0 drain", 4'b0000, 4'b0000, 0);

    // Lane 1: different targets, both granted
    lfdb_vld[1]  = 1'b1;
    lfdb_pld[1]  = mk(1'b1, 32'hB000_0002);
    south_vld[1] = 1'b1;
    south_pld[1] = mk(1'b0, 32'hC000_0003);
    step("l1 dual", 4'b0010, 4'b0010, 0);
    lfdb_vld  = '0;
    south_vld = '0;
    step("l1 drain", 4'b0000, 4'b0000, 0);

    // Lane 2: sustained conflict on RAM 4, south wins every 5th
    ld = 32'h100;
    sd = 32'h200;
    lfdb_vld[2]  = 1'b1;
    south_vld[2] = 1'b1;
    lfdb_pld[2]  = mk(1'b0, ld);
    south_pld[2] = mk(1'b0, sd);
    for (int c = 0; c < 10; c++) begin
      sw = ((c % 5) == 4);
      step($sformatf("l2 c%0d", c), sw ? 4'b0000 : 4'b0100, sw ? 4'b0100 : 4'b0000, 1);
      if (sw) begin sd++; south_pld[2] = mk(1'b0, sd); end
      else    begin ld++; lfdb_pld[2]  = mk(1'b0, ld); end
    end
    lfdb_vld  = '0;
    south_vld = '0;
    step("l2 drain", 4'b0000, 4'b0000, 0);

    // Lane 3: three losses, stall on busy RAM 6, then starvation bound
    ld = 32'h300;
    sd = 32'h400;
    lfdb_vld[3]  = 1'b1;
    south_vld[3] = 1'b1;
    lfdb_pld[3]  = mk(1'b0, ld);
    south_pld[3] = mk(1'b0, sd);
    held = lfdb_pld[3];
    for (int c = 0; c < 3; c++) begin
      held = lfdb_pld[3];
      step($sformatf("l3 pre%0d", c), 4'b1000, 4'b0000, 1);
      ld++;
      lfdb_pld[3] = mk(1'b0, ld);
    end
    ram_rdy[6] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step($sformatf("l3 stall%0d", c), 4'b0000, 4'b0000, 0);
      chk($sformatf("l3 stall%0d hold", c), 64'(ram_pld[6]), 64'(held));
    end
    ram_rdy[6] = 1'b1;
    step("l3 rel lfdb", 4'b1000, 4'b0000, 1);
    ld++;
    lfdb_pld[3] = mk(1'b0, ld);
    step("l3 rel south", 4'b0000, 4'b1000, 1);
    lfdb_vld  = '0;
    south_vld = '0;
    step("l3 drain", 4'b0000, 4'b0000, 0);

    // Fill all 8 slots, then async reset mid-cycle
    for (int i = 0; i < LANE_NUM; i++) begin
      lfdb_pld[i]  = mk(1'b0, 32'hD000_0000 + 32'(i));
      south_pld[i] = mk(1'b1, 32'hE000_0000 + 32'(i));
    end
    lfdb_vld  = '1;
    south_vld = '1;
    step("fill", 4'b1111, 4'b1111, 0);
    lfdb_vld  = '0;
    south_vld = '0;
    ram_rdy   = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("async rst ram_vld", 64'(ram_vld), 64'h0);
    chk("async rst conflict_cnt", 64'(conflict_cnt), 64'h0);
    chk("async rst ram_pld[5]", 64'(ram_pld[5]), 64'h0);
    exp_vld = '0;
    exp_cc  = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post rst 0", 4'b0000, 4'b0000, 0);
    step("post rst 1", 4'b0000, 4'b0000, 0);

    // Counter saturation: 4 conflicts per cycle for 17500 cycles
    ram_rdy = '1;
    for (int i = 0; i < LANE_NUM; i++) begin
      lfdb_pld[i]  = mk(1'b0, 32'h5000 + 32'(i));
      south_pld[i] = mk(1'b0, 32'h6000 + 32'(i));
    end
    lfdb_vld  = '1;
    south_vld = '1;
    step("sat first", 4'b1111, 4'b0000, 4);
    repeat (15999) @(posedge clk);
    #1;
    chk("sat 16000 cycles", 64'(conflict_cnt), 64'd64000);
    repeat (1500) @(posedge clk);
    #1;
    chk("sat 70000 conflicts", 64'(conflict_cnt), 64'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat hold", 64'(conflict_cnt), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/south_write_arb.md
# south_write_arb

Per-lane arbiter and output stage for the south write channel: each of the 4 south lanes feeds an even/odd RAM pair, shared between linefill data-buffer (LFDB) refill writes and south-side write commands. Picks winners when both requesters target the same RAM, prevents south starvation with a bounded counter, and registers the result into a 1-deep valid/ready slot per RAM. Sits between the south channel map and the 8 south RAM write ports.

## Interface
- `LANE_NUM`, default 4: number of south lanes; each lane owns RAM slots 2i and 2i+1.
- `STARVE_MAX`, default 4: consecutive conflict losses after which south wins one conflict.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `lfdb_vld` input LANE_NUM: LFDB refill write request per lane.
- `lfdb_pld` input write_ram_pld_t[LANE_NUM]: refill payload; `write_cmd.req_cmd_pld.dest_ram_id[0]` selects odd (1) or even (0) RAM.
- `lfdb_rdy` output LANE_NUM: refill write accepted this cycle.
- `south_vld` input LANE_NUM: south write command request per lane.
- `south_pld` input write_ram_pld_t[LANE_NUM]: south payload, same RAM select bit.
- `south_rdy` output LANE_NUM: south write accepted this cycle.
- `ram_vld` output 2*LANE_NUM: registered write valid per RAM.
- `ram_pld` output write_ram_pld_t[2*LANE_NUM]: registered write payload per RAM.
- `ram_rdy` input 2*LANE_NUM: RAM accepts write; transfer when `ram_vld && ram_rdy`.
- `conflict_cnt` output 16: saturating count of same-RAM conflicts across all lanes, for perf monitoring.

## Operation
- Per lane i: target t_L = 2i + lfdb dest bit, t_S = 2i + south dest bit. Slot k is free when `!ram_vld[k] || ram_rdy[k]`.
- No conflict (one request, or targets differ): each requester granted iff its target slot is free; both may be granted in the same cycle.
- Conflict (both valid, same target): if slot busy, neither granted, counter unchanged. If slot free: south wins when `starve_cnt[i] == STARVE_MAX`, otherwise LFDB wins; loser's rdy is 0.
- `starve_cnt[i]` (width $clog2(STARVE_MAX+1)): +1, saturating, when south loses a conflict with the slot free; cleared to 0 whenever south is granted; held otherwise, including stalls caused only by a busy slot.
- `lfdb_rdy[i]` / `south_rdy[i]` equal their grant; they are combinational from `*_vld`, payload select bits, `ram_vld` and `ram_rdy`. Requesters must hold vld and pld stable until rdy.
- Slot update: on grant, `ram_vld[k]` <= 1, `ram_pld[k]` <= granted payload; else if `ram_rdy[k]`, `ram_vld[k]` <= 0; else hold.
- A slot is only loaded from its own lane; at most one grant per slot per cycle.
- `conflict_cnt` increments by the number of lanes with a conflict and a free slot this cycle, saturating at 0xFFFF.

## Timing
- Reset (async assert, sync release): `ram_vld` = 0, `ram_pld` = 0, `starve_cnt` = 0, `conflict_cnt` = 0. `lfdb_rdy` and `south_rdy` are 0 while their vld is 0.
- Latency: request granted in cycle N appears on `ram_vld`/`ram_pld` in cycle N+1.
- Full throughput: a slot with `ram_rdy` held high accepts one write per cycle (back-to-back).
- Slot draining and refilling in the same cycle: the new payload replaces the old; `ram_vld` stays 1.
- Reset mid-operation drops all pending slot contents; nothing is replayed.

## Structure
- `write_ram_pld_t` and the RAM select bit position come from `vector_cache_pkg`; add `SOUTH_STARVE_MAX` there as the default source for `STARVE_MAX`.
- Sub-module `south_write_arb_lane`: one lane's arbitration, starve counter and two output slots. The top level instantiates `LANE_NUM` copies and sums the per-lane conflict pulses into `conflict_cnt`.

## Test plan
- After reset, all vld low: `ram_vld` = 0x00 and `conflict_cnt` = 0. Then lane 0 LFDB with dest 0: `lfdb_rdy[0]` = 1, next cycle `ram_vld` = 0x01 with the LFDB payload.
- Lane 1, LFDB dest 1 and south dest 0 in the same cycle, `ram_rdy` all 1: both rdy = 1, next cycle `ram_vld[2]` and `ram_vld[3]` = 1 with the south and LFDB payloads respectively.
- Lane 2, both targeting RAM 4 continuously, `ram_rdy` = 1, STARVE_MAX = 4: LFDB wins 4 cycles, south wins the 5th, then the pattern repeats; `conflict_cnt` increments once per cycle.
- Lane 3, slot 6 holding data with `ram_rdy[6]` = 0 for 3 cycles and both requesters targeting RAM 6: no grants, `starve_cnt` unchanged, `ram_pld[6]` unchanged; on `ram_rdy[6]` = 1, the winner is loaded the next cycle.
- `rst_n` asserted while `ram_vld` = 0xFF: all outputs clear immediately, before any clock edge; after release, no writes are replayed.
- Drive 70000 forced conflicts: `conflict_cnt` saturates at 0xFFFF.
